// File: rtl/alu_arb_pkg.sv
// Shared widths, FSM state encoding and operation payload for the ALU arbiter.
package alu_arb_pkg;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned SHAMT_W = 5;
  localparam int unsigned FUNCT_W = 4;
  // Wide enough for the largest supported ALU latency (7).
  localparam int unsigned CNT_W   = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic [DATA_W-1:0]  a;
    logic [DATA_W-1:0]  b;
    logic [SHAMT_W-1:0] shamt;
    logic [FUNCT_W-1:0] funct;
  } alu_op_t;

endpackage

// File: rtl/alu_arbiter_rr_arb2.sv
// Combinational two-way round-robin: on a tie, the requester not granted last wins.
module rr_arb2 (
  input  logic valid0_i,
  input  logic valid1_i,
  input  logic last_gnt_i,
  output logic gnt_o,
  output logic any_o
);

  // Grant index and any-grant from the two valids.
  always_comb begin
    gnt_o = 1'b0;
    any_o = valid0_i | valid1_i;
    if (valid0_i && valid1_i) begin
      gnt_o = ~last_gnt_i;
    end else if (valid1_i) begin
      gnt_o = 1'b1;
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between two requesters: arbitrate, drive operands, wait, return result.
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int unsigned ALU_LAT = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               r0_req_valid,
  input  logic               r1_req_valid,
  output logic               r0_req_ready,
  output logic               r1_req_ready,
  input  logic [DATA_W-1:0]  r0_a,
  input  logic [DATA_W-1:0]  r0_b,
  input  logic [DATA_W-1:0]  r1_a,
  input  logic [DATA_W-1:0]  r1_b,
  input  logic [SHAMT_W-1:0] r0_shamt,
  input  logic [SHAMT_W-1:0] r1_shamt,
  input  logic [FUNCT_W-1:0] r0_funct,
  input  logic [FUNCT_W-1:0] r1_funct,
  output logic               r0_rsp_valid,
  output logic               r1_rsp_valid,
  input  logic               r0_rsp_ready,
  input  logic               r1_rsp_ready,
  output logic [DATA_W-1:0]  rsp_data,
  output logic [DATA_W-1:0]  alu_a,
  output logic [DATA_W-1:0]  alu_b,
  output logic [SHAMT_W-1:0] alu_shamt,
  output logic [FUNCT_W-1:0] alu_funct,
  input  logic [DATA_W-1:0]  alu_out,
  output logic               busy
);

  arb_state_t        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              gnt_q, gnt_d;
  logic              last_gnt_q, last_gnt_d;
  alu_op_t           op_q, op_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              r0_rsp_valid_q, r0_rsp_valid_d;
  logic              r1_rsp_valid_q, r1_rsp_valid_d;
  logic              busy_q, busy_d;

  logic              arb_gnt;
  logic              arb_any;
  logic              accept;
  logic              rsp_take;
  alu_op_t           req_op;

  rr_arb2 u_rr_arb2 (
    .valid0_i   (r0_req_valid),
    .valid1_i   (r1_req_valid),
    .last_gnt_i (last_gnt_q),
    .gnt_o      (arb_gnt),
    .any_o      (arb_any)
  );

  // Handshake qualification; ready is forced low while reset is held.
  always_comb begin
    accept       = rst_n && (state_q == IDLE) && arb_any;
    r0_req_ready = accept && !arb_gnt;
    r1_req_ready = accept && arb_gnt;
    rsp_take     = gnt_q ? r1_rsp_ready : r0_rsp_ready;
  end

  // Payload of the requester currently winning arbitration.
  always_comb begin
    req_op = '0;
    if (arb_gnt) begin
      req_op.a     = r1_a;
      req_op.b     = r1_b;
      req_op.shamt = r1_shamt;
      req_op.funct = r1_funct;
    end else begin
      req_op.a     = r0_a;
      req_op.b     = r0_b;
      req_op.shamt = r0_shamt;
      req_op.funct = r0_funct;
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    gnt_d          = gnt_q;
    last_gnt_d     = last_gnt_q;
    op_d           = op_q;
    rsp_data_d     = rsp_data_q;
    r0_rsp_valid_d = r0_rsp_valid_q;
    r1_rsp_valid_d = r1_rsp_valid_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          op_d       = req_op;
          gnt_d      = arb_gnt;
          last_gnt_d = arb_gnt;
          cnt_d      = CNT_W'(ALU_LAT);
          state_d    = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          rsp_data_d     = alu_out;
          r0_rsp_valid_d = !gnt_q;
          r1_rsp_valid_d = gnt_q;
          state_d        = RESP;
        end
      end
      RESP: begin
        if (rsp_take) begin
          r0_rsp_valid_d = 1'b0;
          r1_rsp_valid_d = 1'b0;
          state_d        = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      gnt_q          <= 1'b0;
      last_gnt_q     <= 1'b1;
      op_q           <= '0;
      rsp_data_q     <= '0;
      r0_rsp_valid_q <= 1'b0;
      r1_rsp_valid_q <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      gnt_q          <= gnt_d;
      last_gnt_q     <= last_gnt_d;
      op_q           <= op_d;
      rsp_data_q     <= rsp_data_d;
      r0_rsp_valid_q <= r0_rsp_valid_d;
      r1_rsp_valid_q <= r1_rsp_valid_d;
      busy_q         <= busy_d;
    end
  end

  assign alu_a        = op_q.a;
  assign alu_b        = op_q.b;
  assign alu_shamt    = op_q.shamt;
  assign alu_funct    = op_q.funct;
  assign rsp_data     = rsp_data_q;
  assign r0_rsp_valid = r0_rsp_valid_q;
  assign r1_rsp_valid = r1_rsp_valid_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench: three arbiters (ALU_LAT 0, 1, 3) on shared requester stimulus.
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        r0_req_valid, r1_req_valid;
  logic [31:0] r0_a, r0_b, r1_a, r1_b;
  logic [4:0]  r0_shamt, r1_shamt;
  logic [3:0]  r0_funct, r1_funct;
  logic        r0_rsp_ready, r1_rsp_ready;

  // ALU_LAT = 1 instance (main checks)
  logic        r0_req_ready, r1_req_ready, r0_rsp_valid, r1_rsp_valid, busy;
  logic [31:0] rsp_data, alu_a, alu_b, alu_out;
  logic [4:0]  alu_shamt;
  logic [3:0]  alu_funct;
  // ALU_LAT = 0 instance
  logic        r0_req_ready_l0, r1_req_ready_l0, r0_rsp_valid_l0, r1_rsp_valid_l0, busy_l0;
  logic [31:0] rsp_data_l0, alu_a_l0, alu_b_l0, alu_out_l0;
  logic [4:0]  alu_shamt_l0;
  logic [3:0]  alu_funct_l0;
  // ALU_LAT = 3 instance
  logic        r0_req_ready_l3, r1_req_ready_l3, r0_rsp_valid_l3, r1_rsp_valid_l3, busy_l3;
  logic [31:0] rsp_data_l3, alu_a_l3, alu_b_l3, alu_out_l3;
  logic [4:0]  alu_shamt_l3;
  logic [3:0]  alu_funct_l3;

  logic [31:0] p1, p3_0, p3_1, p3_2;
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ALU models: a + b delayed by the instance latency.
  assign alu_out_l0 = alu_a_l0 + alu_b_l0;
  always @(posedge clk) p1 <= alu_a + alu_b;
  assign alu_out = p1;
  always @(posedge clk) begin
    p3_0 <= alu_a_l3 + alu_b_l3;
    p3_1 <= p3_0;
    p3_2 <= p3_1;
  end
  assign alu_out_l3 = p3_2;

  alu_arbiter #(.ALU_LAT(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .r0_req_valid(r0_req_valid), .r1_req_valid(r1_req_valid),
    .r0_req_ready(r0_req_ready), .r1_req_ready(r1_req_ready),
    .r0_a(r0_a), .r0_b(r0_b), .r1_a(r1_a), .r1_b(r1_b),
    .r0_shamt(r0_shamt), .r1_shamt(r1_shamt), .r0_funct(r0_funct), .r1_funct(r1_funct),
    .r0_rsp_valid(r0_rsp_valid), .r1_rsp_valid(r1_rsp_valid),
    .r0_rsp_ready(r0_rsp_ready), .r1_rsp_ready(r1_rsp_ready),
    .rsp_data(rsp_data), .alu_a(alu_a), .alu_b(alu_b),
    .alu_shamt(alu_shamt), .alu_funct(alu_funct), .alu_out(alu_out), .busy(busy)
  );

  alu_arbiter #(.ALU_LAT(0)) dut_l0 (
    .clk(clk), .rst_n(rst_n),
    .r0_req_valid(r0_req_valid), .r1_req_valid(r1_req_valid),
    .r0_req_ready(r0_req_ready_l0), .r1_req_ready(r1_req_ready_l0),
    .r0_a(r0_a), .r0_b(r0_b), .r1_a(r1_a), .r1_b(r1_b),
    .r0_shamt(r0_shamt), .r1_shamt(r1_shamt), .r0_funct(r0_funct), .r1_funct(r1_funct),
    .r0_rsp_valid(r0_rsp_valid_l0), .r1_rsp_valid(r1_rsp_valid_l0),
    .r0_rsp_ready(r0_rsp_ready), .r1_rsp_ready(r1_rsp_ready),
    .rsp_data(rsp_data_l0), .alu_a(alu_a_l0), .alu_b(alu_b_l0),
    .alu_shamt(alu_shamt_l0), .alu_funct(alu_funct_l0), .alu_out(alu_out_l0), .busy(busy_l0)
  );

  alu_arbiter #(.ALU_LAT(3)) dut_l3 (
    .clk(clk), .rst_n(rst_n),
    .r0_req_valid(r0_req_valid), .r1_req_valid(r1_req_valid),
    .r0_req_ready(r0_req_ready_l3), .r1_req_ready(r1_req_ready_l3),
    .r0_a(r0_a), .r0_b(r0_b), .r1_a(r1_a), .r1_b(r1_b),
    .r0_shamt(r0_shamt), .r1_shamt(r1_shamt), .r0_funct(r0_funct), .r1_funct(r1_funct),
    .r0_rsp_valid(r0_rsp_valid_l3), .r1_rsp_valid(r1_rsp_valid_l3),
    .r0_rsp_ready(r0_rsp_ready), .r1_rsp_ready(r1_rsp_ready),
    .rsp_data(rsp_data_l3), .alu_a(alu_a_l3), .alu_b(alu_b_l3),
    .alu_shamt(alu_shamt_l3), .alu_funct(alu_funct_l3), .alu_out(alu_out_l3), .busy(busy_l3)
  );

  // Advance to the sampling point of the next cycle.
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    r0_req_valid = 1'b0;
    r1_req_valid = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    r0_a = 32'd11; r0_b = 32'd22; r1_a = 32'd33; r1_b = 32'd44;
    r0_shamt = 5'd0; r1_shamt = 5'd0; r0_funct = 4'h3; r1_funct = 4'hA;
    r0_rsp_ready = 1'b0; r1_rsp_ready = 1'b0;
    r0_req_valid = 1'b1; r1_req_valid = 1'b1;
    repeat (4) tick();
    checks++;
    if ({r0_req_ready, r1_req_ready} !== 2'b00) begin
      errors++; $display("FAIL reset_req_ready: got %b required 00", {r0_req_ready, r1_req_ready});
    end
    checks++;
    if ({r0_rsp_valid, r1_rsp_valid, busy} !== 3'b000) begin
      errors++; $display("FAIL reset_valid_busy: got %b required 000", {r0_rsp_valid, r1_rsp_valid, busy});
    end
    checks++;
    if ({rsp_data, alu_a, alu_b, alu_shamt, alu_funct} !== 105'd0) begin
      errors++; $display("FAIL reset_data: rsp_data %0h alu_a %0h alu_b %0h shamt %0h funct %0h required all 0",
                         rsp_data, alu_a, alu_b, alu_shamt, alu_funct);
    end
    r0_req_valid = 1'b0; r1_req_valid = 1'b0;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    bit seen;
    r0_a = 32'd5; r0_b = 32'd3; r0_funct = 4'h1;
    r0_rsp_ready = 1'b1; r1_rsp_ready = 1'b1;
    r0_req_valid = 1'b1;
    #1;
    checks++;
    if ({r0_req_ready, r1_req_ready} !== 2'b10) begin
      errors++; $display("FAIL single_ready_T: got %b required 10", {r0_req_ready, r1_req_ready});
    end
    tick();
    r0_req_valid = 1'b0;
    checks++;
    if (busy !== 1'b1 || alu_a !== 32'd5 || alu_b !== 32'd3 || r0_req_ready !== 1'b0) begin
      errors++; $display("FAIL single_T1: busy %b alu_a %0d alu_b %0d ready %b required 1 5 3 0",
                         busy, alu_a, alu_b, r0_req_ready);
    end
    tick();
    checks++;
    if (r0_rsp_valid !== 1'b0) begin
      errors++; $display("FAIL single_T2_valid: got %b required 0", r0_rsp_valid);
    end
    tick();
    checks++;
    if (r0_rsp_valid !== 1'b1 || r1_rsp_valid !== 1'b0 || rsp_data !== 32'd8) begin
      errors++; $display("FAIL single_T3_rsp: r0v %b r1v %b data %0d required 1 0 8",
                         r0_rsp_valid, r1_rsp_valid, rsp_data);
    end
    tick();
    r1_a = 32'd10; r1_b = 32'd20;
    r1_req_valid = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || r0_rsp_valid !== 1'b0 || r1_req_ready !== 1'b1) begin
      errors++; $display("FAIL single_T4_idle: busy %b r0v %b r1_ready %b required 0 0 1",
                         busy, r0_rsp_valid, r1_req_ready);
    end
    tick();
    r1_req_valid = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 12; k++) begin
      if (r1_rsp_valid) begin seen = 1'b1; break; end
      tick();
    end
    checks++;
    if (!seen || rsp_data !== 32'd30 || r0_rsp_valid !== 1'b0) begin
      errors++; $display("FAIL single_r1_rsp: seen %b data %0d r0v %b required 1 30 0",
                         seen, rsp_data, r0_rsp_valid);
    end
    tick();
  endtask

  task automatic test_tie();
    bit seen;
    bit ex;
    int t_prev;
    do_reset();
    r0_a = 32'd1; r0_b = 32'd2; r0_funct = 4'h3;
    r1_a = 32'd10; r1_b = 32'd20; r1_funct = 4'hA;
    r0_rsp_ready = 1'b1; r1_rsp_ready = 1'b1;
    r0_req_valid = 1'b1; r1_req_valid = 1'b1;
    #1;
    t_prev = -1;
    for (int op = 0; op < 6; op++) begin
      ex = op[0];
      seen = 1'b0;
      for (int k = 0; k < 12; k++) begin
        if (r0_req_ready || r1_req_ready) begin seen = 1'b1; break; end
        tick();
      end
      checks++;
      if (!seen || {r1_req_ready, r0_req_ready} !== (ex ? 2'b10 : 2'b01)) begin
        errors++; $display("FAIL tie_grant op%0d: seen %b ready(r1,r0) %b required grant r%0d",
                           op, seen, {r1_req_ready, r0_req_ready}, ex);
      end
      if (t_prev >= 0) begin
        checks++;
        if (cyc - t_prev !== 4) begin
          errors++; $display("FAIL tie_period op%0d: got %0d cycles required 4", op, cyc - t_prev);
        end
      end
      t_prev = cyc;
      tick();
      checks++;
      if (alu_funct !== (ex ? 4'hA : 4'h3)) begin
        errors++; $display("FAIL tie_funct op%0d: got %0h required %0h", op, alu_funct, ex ? 4'hA : 4'h3);
      end
      seen = 1'b0;
      for (int k = 0; k < 12; k++) begin
        if (ex ? r1_rsp_valid : r0_rsp_valid) begin seen = 1'b1; break; end
        tick();
      end
      checks++;
      if (!seen || rsp_data !== (ex ? 32'd30 : 32'd3)) begin
        errors++; $display("FAIL tie_rsp op%0d: seen %b data %0d required %0d", op, seen, rsp_data, ex ? 30 : 3);
      end
    end
    r0_req_valid = 1'b0; r1_req_valid = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_backpressure();
    bit seen;
    r1_a = 32'd7; r1_b = 32'd9;
    r0_rsp_ready = 1'b1; r1_rsp_ready = 1'b0;
    r1_req_valid = 1'b1;
    #1;
    checks++;
    if (r1_req_ready !== 1'b1) begin
      errors++; $display("FAIL bp_accept: got %b required 1", r1_req_ready);
    end
    tick();
    r1_req_valid = 1'b0;
    r0_a = 32'd4; r0_b = 32'd4; r0_req_valid = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 12; k++) begin
      if (r1_rsp_valid) begin seen = 1'b1; break; end
      tick();
    end
    checks++;
    if (!seen) begin
      errors++; $display("FAIL bp_rsp_timeout: r1_rsp_valid %b required 1", r1_rsp_valid);
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (r1_rsp_valid !== 1'b1 || rsp_data !== 32'd16 || r0_req_ready !== 1'b0 || r0_rsp_valid !== 1'b0) begin
        errors++; $display("FAIL bp_hold cycle%0d: r1v %b data %0d r0_ready %b r0v %b required 1 16 0 0",
                           i, r1_rsp_valid, rsp_data, r0_req_ready, r0_rsp_valid);
      end
      if (i < 4) tick();
    end
    r1_rsp_ready = 1'b1;
    tick();
    checks++;
    if (r1_rsp_valid !== 1'b0 || busy !== 1'b0 || r0_req_ready !== 1'b1) begin
      errors++; $display("FAIL bp_resume: r1v %b busy %b r0_ready %b required 0 0 1",
                         r1_rsp_valid, busy, r0_req_ready);
    end
    tick();
    r0_req_valid = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 12; k++) begin
      if (r0_rsp_valid) begin seen = 1'b1; break; end
      tick();
    end
    checks++;
    if (!seen || rsp_data !== 32'd8) begin
      errors++; $display("FAIL bp_r0_rsp: seen %b data %0d required 1 8", seen, rsp_data);
    end
    tick();
  endtask

  task automatic test_lat_sweep();
    do_reset();
    r0_a = 32'd6; r0_b = 32'd7;
    r0_rsp_ready = 1'b1; r1_rsp_ready = 1'b1;
    r0_req_valid = 1'b1;
    #1;
    checks++;
    if ({r0_req_ready_l0, r0_req_ready, r0_req_ready_l3} !== 3'b111) begin
      errors++; $display("FAIL sweep_accept: got %b required 111", {r0_req_ready_l0, r0_req_ready, r0_req_ready_l3});
    end
    for (int k = 1; k <= 6; k++) begin
      tick();
      r0_req_valid = 1'b0;
      checks++;
      if (r0_rsp_valid_l0 !== (k == 2) || (k == 2 && rsp_data_l0 !== 32'd13)) begin
        errors++; $display("FAIL sweep_lat0 T+%0d: valid %b data %0d required %b 13", k, r0_rsp_valid_l0, rsp_data_l0, k == 2);
      end
      checks++;
      if (r0_rsp_valid !== (k == 3) || (k == 3 && rsp_data !== 32'd13)) begin
        errors++; $display("FAIL sweep_lat1 T+%0d: valid %b data %0d required %b 13", k, r0_rsp_valid, rsp_data, k == 3);
      end
      checks++;
      if (r0_rsp_valid_l3 !== (k == 5) || (k == 5 && rsp_data_l3 !== 32'd13)) begin
        errors++; $display("FAIL sweep_lat3 T+%0d: valid %b data %0d required %b 13", k, r0_rsp_valid_l3, rsp_data_l3, k == 5);
      end
    end
  endtask

  task automatic test_reset_mid_busy();
    bit seen;
    bit leaked;
    r0_a = 32'd100; r0_b = 32'd200;
    r0_req_valid = 1'b1;
    #1;
    checks++;
    if (r0_req_ready !== 1'b1) begin
      errors++; $display("FAIL rmb_accept: got %b required 1", r0_req_ready);
    end
    tick();
    r0_req_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL rmb_busy_before: got %b required 1", busy);
    end
    tick();
    checks++;
    if ({busy, r0_rsp_valid, r1_rsp_valid, r0_req_ready, r1_req_ready} !== 5'd0 ||
        {alu_a, alu_b, rsp_data} !== 96'd0) begin
      errors++; $display("FAIL rmb_cleared: busy %b r0v %b alu_a %0d alu_b %0d data %0d required all 0",
                         busy, r0_rsp_valid, alu_a, alu_b, rsp_data);
    end
    tick();
    rst_n = 1'b1;
    leaked = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (r0_rsp_valid || r1_rsp_valid) leaked = 1'b1;
    end
    checks++;
    if (leaked !== 1'b0) begin
      errors++; $display("FAIL rmb_no_rsp: got response %b required 0", leaked);
    end
    r0_a = 32'd1; r0_b = 32'd1; r1_a = 32'd2; r1_b = 32'd2;
    r0_req_valid = 1'b1; r1_req_valid = 1'b1;
    #1;
    checks++;
    if ({r0_req_ready, r1_req_ready} !== 2'b10) begin
      errors++; $display("FAIL rmb_tie_r0: got %b required 10", {r0_req_ready, r1_req_ready});
    end
    tick();
    r0_req_valid = 1'b0; r1_req_valid = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 12; k++) begin
      if (r0_rsp_valid) begin seen = 1'b1; break; end
      tick();
    end
    checks++;
    if (!seen || rsp_data !== 32'd2) begin
      errors++; $display("FAIL rmb_rsp: seen %b data %0d required 1 2", seen, rsp_data);
    end
    tick();
  endtask

  task automatic test_wrap();
    bit seen;
    r0_a = 32'hFFFF_FFFF; r0_b = 32'd1; r0_funct = 4'hF; r0_shamt = 5'd31;
    r0_rsp_ready = 1'b1;
    r0_req_valid = 1'b1;
    #1;
    checks++;
    if (r0_req_ready !== 1'b1) begin
      errors++; $display("FAIL wrap_accept: got %b required 1", r0_req_ready);
    end
    tick();
    r0_req_valid = 1'b0;
    checks++;
    if (alu_funct !== 4'hF || alu_shamt !== 5'd31 || alu_a !== 32'hFFFF_FFFF || alu_b !== 32'd1) begin
      errors++; $display("FAIL wrap_drive: funct %0h shamt %0d a %0h b %0h required f 31 ffffffff 1",
                         alu_funct, alu_shamt, alu_a, alu_b);
    end
    seen = 1'b0;
    for (int k = 0; k < 12; k++) begin
      if (r0_rsp_valid) begin seen = 1'b1; break; end
      tick();
    end
    checks++;
    if (!seen || rsp_data !== 32'd0) begin
      errors++; $display("FAIL wrap_rsp: seen %b data %0h required 1 0", seen, rsp_data);
    end
    tick();
    tick();
    checks++;
    if (busy !== 1'b0 || alu_a !== 32'hFFFF_FFFF || alu_funct !== 4'hF || alu_shamt !== 5'd31) begin
      errors++; $display("FAIL wrap_hold_idle: busy %b a %0h funct %0h shamt %0d required 0 ffffffff f 31",
                         busy, alu_a, alu_funct, alu_shamt);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_tie();
    test_backpressure();
    test_lat_sweep();
    test_reset_mid_busy();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Two-requester round-robin arbiter and sequencer that shares the single 32-bit `alu` between two independent masters (e.g. the datapath's execute stage and a multi-cycle multiply/divide helper). It accepts one operation at a time via a valid/ready handshake and drives the ALU operand, shift and function ports from registers. It waits a fixed ALU latency, captures the result and returns it to the granted requester through a valid/ready response handshake. The arbiter never decodes `funct`; it passes it through to the ALU unchanged.

## Interface
Parameters:
- `ALU_LAT`, 1: cycles from stable operands at the ALU to a valid `alu_out`; legal range 0..7.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `r0_req_valid`, `r1_req_valid` in 1 each: requester has an operation pending.
- `r0_req_ready`, `r1_req_ready` out 1 each: operation accepted this cycle.
- `r0_a`, `r0_b`, `r1_a`, `r1_b` in 32 each: operands.
- `r0_shamt`, `r1_shamt` in 5 each: shift amount.
- `r0_funct`, `r1_funct` in 4 each: ALU function code, passed through.
- `r0_rsp_valid`, `r1_rsp_valid` out 1 each: result available for that requester.
- `r0_rsp_ready`, `r1_rsp_ready` in 1 each: requester consumes the result.
- `rsp_data` out 32: captured result, shared by both response channels.
- `alu_a`, `alu_b` out 32; `alu_shamt` out 5; `alu_funct` out 4: registered ALU drive.
- `alu_out` in 32: ALU result.
- `busy` out 1: high whenever the state is not IDLE.

## Operation
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - The arbiter computes a grant combinationally from the two `req_valid` inputs.
  - Exactly one `rX_req_ready` is high, and only for a requester whose valid is high.
  - On the handshake edge it registers that requester's a/b/shamt/funct into the `alu_*` regs, records `gnt`, loads `cnt` with `ALU_LAT`, and moves to BUSY.
- Round-robin rule:
  - Only one requester valid: grant it.
  - Both valid: grant the requester that is not `last_gnt`.
  - `last_gnt` updates on every accept.
  - Reset sets `last_gnt` = 1, so r0 wins the first tie.
- BUSY:
  - `alu_*` held stable; both `req_ready` low.
  - While `cnt` != 0, decrement it.
  - When `cnt` == 0, capture `alu_out` into `rsp_data` and move to RESP.
- RESP:
  - `rX_rsp_valid` is high for the granted requester only; `rsp_data` is held.
  - On `rX_rsp_ready`, return to IDLE.
  - The other requester's `rsp_ready` is ignored.
- `alu_*` registers keep their last value in IDLE and RESP; they are not cleared between operations.
- Reset at any time:
  - All state is cleared to IDLE; any in-flight operation is discarded with no response.
  - `cnt` = 0, `gnt` = 0, `last_gnt` = 1.
- Reset values of all outputs are 0: `req_ready`s (combinationally 0 while `rst_n` is low), `rsp_valid`s, `rsp_data`, `alu_a`, `alu_b`, `alu_shamt`, `alu_funct` and `busy`.

## Timing
- Accept edge at end of cycle T.
- `alu_*` are valid from T+1.
- Result captured at the end of cycle T+1+`ALU_LAT`.
- `rsp_valid` is high from T+2+`ALU_LAT`.
- If `rsp_ready` is already high, the FSM is back in IDLE at T+3+`ALU_LAT`, and a new accept can occur in that cycle.
- Minimum issue period: `ALU_LAT`+3 cycles; with `ALU_LAT`=1, 4 cycles.
- `req_ready` is never asserted outside IDLE. Requesters hold valid and payload stable until ready.
- `rsp_valid` stays high with stable `rsp_data` until the matching `rsp_ready`; backpressure of any length is legal.
- A requester that drops `req_valid` before ready loses nothing: no grant, no `last_gnt` change.

## Structure
- Package `alu_arb_pkg`:
  - `DATA_W`=32, `SHAMT_W`=5, `FUNCT_W`=4.
  - State enum `arb_state_t` {IDLE, BUSY, RESP}.
- Sub-module `rr_arb2`:
  - Combinational 2-way round-robin.
  - Inputs: two valids and `last_gnt`. Outputs: grant index and any-grant.
- `alu` is not instantiated here. The enclosing top wires `alu_*`/`alu_out` to the shared ALU instance.

## Test plan
Bench ALU model returns `alu_a + alu_b` after `ALU_LAT` cycles for any funct.
- Single request: r0 sends a=5, b=3, `ALU_LAT`=1, `rsp_ready` tied high -> `r0_req_ready` at T, `r0_rsp_valid` at T+3 with `rsp_data`=8, back in IDLE at T+4; r1 sees no response.
- Simultaneous requests from reset: r0 (1,2) and r1 (10,20) held valid -> r0 served first (3), then r1 (30), then r0 again if re-presented; grants strictly alternate over 6 ops.
- Response backpressure: r1 `rsp_ready` held low for 5 cycles -> `r1_rsp_valid` and `rsp_data` stable for all 5, no new accept from r0 during that time; accept resumes the cycle after IDLE.
- `ALU_LAT` sweep 0, 1, 3 -> `rsp_valid` at T+2, T+3, T+5 respectively; data matches the model.
- Reset mid-BUSY: assert `rst_n`=0 one cycle after accept -> next cycle all outputs 0, no `rsp_valid` ever for that operation; first tie after reset goes to r0.
- Wrap values: a=32'hFFFF_FFFF, b=1 -> `rsp_data`=0, funct/shamt (4'hF, 5'd31) observed unchanged on `alu_funct`/`alu_shamt`.
